// File: rtl/segre_icache_refill.sv
// segre_icache_refill: icache miss handler, bursts one lane from memory then writes it to the data/tag arrays
// Optional feature: define SEGRE_ICACHE_REFILL_PERF_EN to add saturating refill/abort counters.
module segre_icache_refill #(
    parameter int ADDR_SIZE  = 32,
    parameter int WORD_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int INDEX_SIZE = 6,
    parameter int TAG_SIZE   = ADDR_SIZE - INDEX_SIZE - $clog2(LANE_SIZE / 8)
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  miss_i,
    input  logic [ADDR_SIZE-1:0]  miss_addr_i,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [ADDR_SIZE-1:0]  mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_SIZE-1:0]  mem_rdata_i,
    output logic                  cache_wr_o,
    output logic [INDEX_SIZE-1:0] cache_index_o,
    output logic [TAG_SIZE-1:0]   cache_tag_o,
    output logic [LANE_SIZE-1:0]  cache_line_o,
    output logic                  refill_done_o,
    output logic                  busy_o
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]           refill_cnt_o,
    output logic [31:0]           abort_cnt_o
`endif
);
    localparam int NUM_BEATS = LANE_SIZE / WORD_SIZE;
    localparam int BYTE_SIZE = $clog2(LANE_SIZE / 8);
    localparam int CNT_SIZE  = $clog2(NUM_BEATS) + 1;
    localparam int WORD_OFF  = $clog2(WORD_SIZE / 8);
    localparam logic [CNT_SIZE-1:0]  BEATS     = CNT_SIZE'(NUM_BEATS);
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'(LANE_SIZE / 8 - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DRAIN} state_t;

    state_t                state, next_state;
    logic [ADDR_SIZE-1:0]  base;
    logic [CNT_SIZE-1:0]   req_cnt, rsp_cnt, req_next, rsp_next;
    logic [LANE_SIZE-1:0]  buffer;
    logic                  gnt, rsp, flush_taken, write;

    // Accepted handshakes, next counts and next state; a flush in REQ/WAIT overrides normal progress
    always_comb begin
        gnt         = (state == S_REQ) && mem_gnt_i;
        rsp         = (state inside {S_REQ, S_WAIT, S_DRAIN}) && mem_rvalid_i && (req_cnt != rsp_cnt);
        req_next    = req_cnt + CNT_SIZE'(gnt);
        rsp_next    = rsp_cnt + CNT_SIZE'(rsp);
        flush_taken = (state inside {S_REQ, S_WAIT}) && flush_i;
        next_state  = state;
        case (state)
            S_IDLE:  next_state = miss_i ? S_REQ : S_IDLE;
            S_REQ:   next_state = (req_next != BEATS) ? S_REQ : (rsp_next == BEATS) ? S_WRITE : S_WAIT;
            S_WAIT:  next_state = (rsp_next == BEATS) ? S_WRITE : S_WAIT;
            S_WRITE: next_state = S_IDLE;
            S_DRAIN: next_state = (req_cnt == rsp_next) ? S_IDLE : S_DRAIN;
            default: next_state = S_IDLE;
        endcase
        if (flush_taken)
            next_state = (req_next != rsp_next) ? S_DRAIN : S_IDLE;
    end

    // Output decode; array-side outputs are zero except in the single WRITE cycle
    always_comb begin
        write         = state == S_WRITE;
        busy_o        = state != S_IDLE;
        mem_req_o     = state == S_REQ;
        mem_addr_o    = (state == S_REQ) ? base + (ADDR_SIZE'(req_cnt) << WORD_OFF) : '0;
        cache_wr_o    = write;
        refill_done_o = write;
        cache_index_o = write ? base[BYTE_SIZE +: INDEX_SIZE] : '0;
        cache_tag_o   = write ? base[ADDR_SIZE-1 -: TAG_SIZE] : '0;
        cache_line_o  = write ? buffer : '0;
    end

    // State, counters, captured line base and beat assembly (drained beats are dropped)
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state   <= S_IDLE;
            base    <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
            buffer  <= '0;
        end else begin
            state   <= next_state;
            req_cnt <= (state == S_IDLE) ? '0 : req_next;
            rsp_cnt <= (state == S_IDLE) ? '0 : rsp_next;
            if (state == S_IDLE && miss_i)
                base <= miss_addr_i & LINE_MASK;
            if (rsp && state != S_DRAIN)
                buffer[rsp_cnt[CNT_SIZE-2:0]*WORD_SIZE +: WORD_SIZE] <= mem_rdata_i;
        end
    end

`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    // Saturating counters of completed writes and of flushes taken in REQ/WAIT
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            refill_cnt_o <= '0;
            abort_cnt_o  <= '0;
        end else begin
            if (write && refill_cnt_o != '1)
                refill_cnt_o <= refill_cnt_o + 32'd1;
            if (flush_taken && abort_cnt_o != '1)
                abort_cnt_o <= abort_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_segre_icache_refill.sv
// tb_segre_icache_refill: randomized and directed checks of the icache refill handler against a transaction-level model
module tb_segre_icache_refill;
    localparam int AW = 32, WW = 32, LW = 128, IW = 6, TW = 22;

    logic          clk_i = 1'b0;
    logic          rsn_i, miss_i, flush_i, mem_gnt_i, mem_rvalid_i;
    logic [AW-1:0] miss_addr_i, mem_addr_o;
    logic [WW-1:0] mem_rdata_i;
    logic          mem_req_o, cache_wr_o, refill_done_o, busy_o;
    logic [IW-1:0] cache_index_o;
    logic [TW-1:0] cache_tag_o;
    logic [LW-1:0] cache_line_o;
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    logic [31:0]   refill_cnt_o, abort_cnt_o;
`endif

    int            n_chk = 0, n_fail = 0;
    int            p_gnt = 100, p_rv = 100, p_flush = 0;
    bit            simple = 0;
    logic [31:0]   pend_q[$];
    logic [31:0]   addr_log[$];
    int            cyc_no, wr_seen, wr_cyc, done_mis, n_done, n_abort;
    bit            in_abort;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic [LW-1:0] wr_line;
    logic          wr_done;

    always #5 clk_i = ~clk_i;

    segre_icache_refill dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .miss_i(miss_i), .miss_addr_i(miss_addr_i), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .cache_wr_o(cache_wr_o), .cache_index_o(cache_index_o), .cache_tag_o(cache_tag_o),
        .cache_line_o(cache_line_o), .refill_done_o(refill_done_o), .busy_o(busy_o)
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
        , .refill_cnt_o(refill_cnt_o), .abort_cnt_o(abort_cnt_o)
`endif
    );

    // Memory contents: either the simple A0..A3 pattern or an address hash
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return simple ? 32'hA0 + {30'b0, a[3:2]} : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [LW-1:0] exp_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word(base + 32'(4 * k));
        return l;
    endfunction

    // One clock of the memory model: respond in order from the pending queue, grant requests, log events
    task automatic cyc(input bit g, input bit r);
        mem_rvalid_i = r && pend_q.size() > 0;
        mem_rdata_i  = $urandom;
        if (mem_rvalid_i) mem_rdata_i = pend_q.pop_front();
        mem_gnt_i = g && mem_req_o;
        if (mem_gnt_i) begin
            addr_log.push_back(mem_addr_o);
            pend_q.push_back(mem_word(mem_addr_o));
        end
        if (cache_wr_o) begin
            wr_seen++; wr_cyc = cyc_no; n_done++;
            wr_idx = cache_index_o; wr_tag = cache_tag_o; wr_line = cache_line_o; wr_done = refill_done_o;
        end
        if (refill_done_o !== cache_wr_o) done_mis++;
        if (!busy_o) in_abort = 0;
        else if (flush_i && !cache_wr_o && !in_abort) begin
            in_abort = 1; n_abort++;
        end
        @(negedge clk_i);
        cyc_no++;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy_o; i++) begin
            flush_i = $urandom_range(99) < p_flush;
            cyc($urandom_range(99) < p_gnt, $urandom_range(99) < p_rv);
        end
        flush_i = 0;
    endtask

    task automatic start_miss(input logic [31:0] a);
        addr_log.delete();
        wr_seen = 0; cyc_no = 0;
        miss_i = 1; miss_addr_i = a;
        cyc(1, 1);
        miss_i = 0; miss_addr_i = $urandom;
    endtask

    task automatic apply_reset();
        #2 rsn_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rsn_i = 1;
        pend_q.delete();
        n_done = 0; n_abort = 0; in_abort = 0; wr_seen = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_chk++;
        if ({mem_req_o, mem_addr_o, cache_wr_o, cache_index_o, cache_tag_o, cache_line_o, refill_done_o, busy_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: busy=%b req=%b addr=%h wr=%b line=%h, required all 0", busy_o, mem_req_o, mem_addr_o, cache_wr_o, cache_line_o);
        end
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
        n_chk++;
        if ({refill_cnt_o, abort_cnt_o} !== 64'd0) begin
            n_fail++; $display("FAIL reset_perf: refill=%0d abort=%0d, required 0 0", refill_cnt_o, abort_cnt_o);
        end
`endif
        rsn_i = 1;
        cyc(0, 0);
        n_chk++;
        if ({busy_o, mem_req_o, cache_wr_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: busy=%b req=%b wr=%b, required 0 0 0", busy_o, mem_req_o, cache_wr_o);
        end
    endtask

    task automatic test_basic();
        simple = 1; p_gnt = 100; p_rv = 100;
        start_miss(32'h0000_1234);
        wait_idle(50);
        n_chk++;
        if (addr_log.size() != 4 || addr_log[0] !== 32'h1230 || addr_log[1] !== 32'h1234 || addr_log[2] !== 32'h1238 || addr_log[3] !== 32'h123C) begin
            n_fail++; $display("FAIL basic_addr: %0d grants first=%h last=%h, required 1230 1234 1238 123C", addr_log.size(), addr_log[0], addr_log[addr_log.size()-1]);
        end
        n_chk++;
        if (wr_seen != 1 || wr_cyc != 6 || wr_done !== 1'b1) begin
            n_fail++; $display("FAIL basic_write: %0d writes at cycle %0d done=%b, required 1 at cycle 6 done=1", wr_seen, wr_cyc, wr_done);
        end
        n_chk++;
        if (wr_idx !== 6'h23 || wr_tag !== 22'h4) begin
            n_fail++; $display("FAIL basic_idx_tag: index=%h tag=%h, required 23 4", wr_idx, wr_tag);
        end
        n_chk++;
        if (wr_line !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_fail++; $display("FAIL basic_line: %h, required 000000a3000000a2000000a1000000a0", wr_line);
        end
        n_chk++;
        if (busy_o !== 1'b0 || cyc_no != 7) begin
            n_fail++; $display("FAIL basic_idle: busy=%b at cycle %0d, required 0 at cycle 7", busy_o, cyc_no);
        end
        simple = 0;
    endtask

    task automatic test_grant_stall();
        bit stable = 1;
        start_miss(32'h0000_1234);
        cyc(1, 1);
        cyc(1, 1);
        for (int i = 0; i < 3; i++) begin
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1238) stable = 0;
            cyc(0, 1);
        end
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1238) stable = 0;
        n_chk++;
        if (!stable) begin
            n_fail++; $display("FAIL stall_hold: req=%b addr=%h at end of stall, required 1 1238 throughout", mem_req_o, mem_addr_o);
        end
        wait_idle(50);
        n_chk++;
        if (wr_seen != 1 || wr_line !== exp_line(32'h1230) || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_line: %0d writes line=%h, required 1 write %h", wr_seen, wr_line, exp_line(32'h1230));
        end
    endtask

    task automatic test_flush();
        start_miss(32'h0000_2008);
        cyc(1, 1);
        cyc(1, 1);
        flush_i = 1;
        cyc(0, 0);
        flush_i = 0;
        n_chk++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_drain: busy=%b req=%b, required 1 0", busy_o, mem_req_o);
        end
        miss_i = 1; miss_addr_i = 32'h0000_7770;
        cyc(0, 1);
        miss_i = 0;
        n_chk++;
        if (busy_o !== 1'b0 || pend_q.size() != 0 || wr_seen != 0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b pending=%0d writes=%0d, required 0 0 0", busy_o, pend_q.size(), wr_seen);
        end
        start_miss(32'h0000_0040);
        wait_idle(50);
        n_chk++;
        if (wr_seen != 1 || wr_idx !== 6'h04 || wr_tag !== 22'h0 || wr_line !== exp_line(32'h40)) begin
            n_fail++; $display("FAIL flush_follow: writes=%0d index=%h tag=%h line=%h, required 1 04 0 %h", wr_seen, wr_idx, wr_tag, wr_line, exp_line(32'h40));
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] a = $urandom & ~32'hF;
        int ab = n_abort;
        start_miss(a);
        for (int i = 0; i < 20 && busy_o; i++) begin
            flush_i = cache_wr_o;
            cyc(1, 1);
            flush_i = 0;
        end
        n_chk++;
        if (wr_seen != 1 || wr_done !== 1'b1 || wr_line !== exp_line(a) || busy_o !== 1'b0 || n_abort != ab) begin
            n_fail++; $display("FAIL same_cycle: writes=%0d done=%b line=%h busy=%b, required 1 1 %h 0", wr_seen, wr_done, wr_line, busy_o, exp_line(a));
        end
    endtask

    task automatic test_async_reset();
        bit stray = 0;
        logic [31:0] a = $urandom & ~32'hF;
        start_miss(32'h0000_3450);
        for (int i = 0; i < 4; i++) cyc(1, 0);
        n_chk++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_wait: busy=%b req=%b, required 1 0", busy_o, mem_req_o);
        end
        #2 rsn_i = 0;
        #1;
        n_chk++;
        if ({mem_req_o, mem_addr_o, cache_wr_o, cache_index_o, cache_tag_o, cache_line_o, refill_done_o, busy_o} !== '0) begin
            n_fail++; $display("FAIL areset_immediate: busy=%b req=%b addr=%h wr=%b, required all 0", busy_o, mem_req_o, mem_addr_o, cache_wr_o);
        end
        @(negedge clk_i);
        rsn_i = 1;
        n_done = 0; n_abort = 0; in_abort = 0; wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy_o || mem_req_o || cache_wr_o) stray = 1;
            cyc(1, 1);
        end
        n_chk++;
        if (stray || busy_o !== 1'b0 || wr_seen != 0 || pend_q.size() != 0) begin
            n_fail++; $display("FAIL areset_stray: disturbed=%b busy=%b writes=%0d, required 0 0 0", stray, busy_o, wr_seen);
        end
        start_miss(a);
        wait_idle(50);
        n_chk++;
        if (wr_seen != 1 || wr_line !== exp_line(a)) begin
            n_fail++; $display("FAIL areset_follow: writes=%0d line=%h, required 1 %h", wr_seen, wr_line, exp_line(a));
        end
    endtask

`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    task automatic test_perf();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            start_miss($urandom);
            wait_idle(50);
        end
        start_miss($urandom);
        flush_i = 1;
        cyc(1, 1);
        flush_i = 0;
        wait_idle(50);
        n_chk++;
        if (refill_cnt_o !== 32'd3 || abort_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL perf_counts: refill=%0d abort=%0d, required 3 1", refill_cnt_o, abort_cnt_o);
        end
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a = $urandom;
            logic [31:0] base = a & ~32'hF;
            int ab = n_abort;
            bit addr_ok = 1;
            p_gnt = $urandom_range(30, 100); p_rv = $urandom_range(30, 100); p_flush = 4;
            start_miss(a);
            wait_idle(300);
            p_flush = 0;
            for (int k = 0; k < addr_log.size(); k++)
                if (addr_log[k] !== base + 32'(4 * k)) addr_ok = 0;
            if (addr_log.size() > 4) addr_ok = 0;
            n_chk++;
            if (!addr_ok || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL rand_addr[%0d]: grants=%0d busy=%b base=%h, required sequential beats then idle", t, addr_log.size(), busy_o, base);
            end
            n_chk++;
            if (n_abort != ab) begin
                if (wr_seen != 0 || pend_q.size() != 0) begin
                    n_fail++; $display("FAIL rand_abort[%0d]: writes=%0d pending=%0d, required 0 0", t, wr_seen, pend_q.size());
                end
            end else if (wr_seen != 1 || addr_log.size() != 4 || wr_line !== exp_line(base) || wr_idx !== IW'(base >> 4) || wr_tag !== TW'(base >> 10)) begin
                n_fail++; $display("FAIL rand_write[%0d]: writes=%0d index=%h tag=%h line=%h, required 1 %h %h %h", t, wr_seen, wr_idx, wr_tag, wr_line, IW'(base >> 4), TW'(base >> 10), exp_line(base));
            end
        end
        p_gnt = 100; p_rv = 100;
        n_chk++;
        if (done_mis != 0) begin
            n_fail++; $display("FAIL done_strobe: %0d cycles with refill_done_o != cache_wr_o, required 0", done_mis);
        end
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
        n_chk++;
        if (refill_cnt_o !== 32'(n_done) || abort_cnt_o !== 32'(n_abort)) begin
            n_fail++; $display("FAIL rand_perf: refill=%0d abort=%0d, required %0d %0d", refill_cnt_o, abort_cnt_o, n_done, n_abort);
        end
`endif
    endtask

    initial begin
        rsn_i = 0; miss_i = 0; miss_addr_i = '0; flush_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        done_mis = 0; n_done = 0; n_abort = 0; in_abort = 0;
        test_reset();
        test_basic();
        test_grant_stall();
        test_flush();
        test_same_cycle();
        test_async_reset();
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
